// File: rtl/mmap_controller.sv
// Memory-mapped access controller: decodes a CPU request onto one of NREG
// regions, strobes it for one cycle, waits a per-region count, then acks.
module mmap_controller #(
    parameter int DW = 16,
    parameter int AW = 16,
    parameter int RSEL = 3,
    parameter int NREG = 5,
    parameter logic [4*NREG-1:0] WAITS = 20'h0_0_1_0_0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req,
    input  logic                 we,
    input  logic [AW-1:0]        addr,
    input  logic [DW-1:0]        wdata,
    output logic                 ready,
    output logic                 ack,
    output logic [DW-1:0]        rdata,
    output logic                 err,
    output logic [NREG-1:0]      reg_en,
    output logic                 reg_we,
    output logic [AW-RSEL-1:0]   reg_addr,
    output logic [DW-1:0]        reg_wdata,
    input  logic [NREG*DW-1:0]   reg_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            state;
    logic              we_l;
    logic [RSEL-1:0]   idx_l;
    logic [3:0]        cnt;
    logic [RSEL-1:0]   acc_idx;
    logic [3:0]        w_sel;

    function automatic logic is_mapped(input logic [RSEL-1:0] idx);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < NREG; k++) begin
            if (idx == RSEL'(k)) hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic logic [NREG-1:0] onehot(input logic [RSEL-1:0] idx);
        logic [NREG-1:0] v;
        v = '0;
        for (int k = 0; k < NREG; k++) begin
            v[k] = (idx == RSEL'(k));
        end
        return v;
    endfunction

    function automatic logic [3:0] wait_of(input logic [RSEL-1:0] idx);
        logic [3:0] w;
        w = 4'd0;
        for (int k = 0; k < NREG; k++) begin
            if (idx == RSEL'(k)) w = WAITS[4*k +: 4];
        end
        return w;
    endfunction

    // Only ever called for mapped indices, so unmatched slices never leak in.
    function automatic logic [DW-1:0] slice_of(input logic [NREG*DW-1:0] bus,
                                               input logic [RSEL-1:0]    idx);
        logic [DW-1:0] s;
        s = '0;
        for (int k = 0; k < NREG; k++) begin
            if (idx == RSEL'(k)) s = bus[DW*k +: DW];
        end
        return s;
    endfunction

    assign acc_idx = addr[AW-1 -: RSEL];
    assign w_sel   = wait_of(idx_l);
    assign ready   = (state == S_IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            we_l      <= 1'b0;
            idx_l     <= '0;
            cnt       <= 4'd0;
            ack       <= 1'b0;
            err       <= 1'b0;
            rdata     <= '0;
            reg_en    <= '0;
            reg_we    <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
        end else begin
            // Strobes and the completion pulse are single-cycle by default.
            ack    <= 1'b0;
            err    <= 1'b0;
            reg_en <= '0;
            reg_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        we_l      <= we;
                        idx_l     <= acc_idx;
                        reg_addr  <= addr[AW-RSEL-1:0];
                        reg_wdata <= wdata;
                        rdata     <= '0;
                        if (is_mapped(acc_idx)) begin
                            state  <= S_ACCESS;
                            reg_en <= onehot(acc_idx);
                            reg_we <= we;
                        end else begin
                            state <= S_RESP;
                            ack   <= 1'b1;
                            err   <= 1'b1;
                        end
                    end
                end
                S_ACCESS: begin
                    cnt <= w_sel;
                    if (w_sel == 4'd0) begin
                        state <= S_RESP;
                        ack   <= 1'b1;
                        if (!we_l) rdata <= slice_of(reg_rdata, idx_l);
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt <= 4'd1) begin
                        cnt   <= 4'd0;
                        state <= S_RESP;
                        ack   <= 1'b1;
                        if (!we_l) rdata <= slice_of(reg_rdata, idx_l);
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
